// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage: PC register, imem req/ack fetch, IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcnext,
  input  logic        if_flush,
  input  logic        stall_if,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] ifid_instr_n, ifid_pc_plus4_n;
  logic        ifid_valid_n;
  logic [31:0] hold_buf, hold_buf_n;
  logic        redirect_pending, redirect_pending_n;
  logic [31:0] redirect_pc, redirect_pc_n;
  logic        ack_fire;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH) && !reset;
  assign ack_fire  = imem_req && imem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      ifid_instr       <= NOP_INSTR;
      ifid_pc_plus4    <= 32'd0;
      ifid_valid       <= 1'b0;
      hold_buf         <= 32'd0;
      redirect_pending <= 1'b0;
      redirect_pc      <= 32'd0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      ifid_instr       <= ifid_instr_n;
      ifid_pc_plus4    <= ifid_pc_plus4_n;
      ifid_valid       <= ifid_valid_n;
      hold_buf         <= hold_buf_n;
      redirect_pending <= redirect_pending_n;
      redirect_pc      <= redirect_pc_n;
    end
  end

  always_comb begin
    state_n            = state;
    pc_n               = pc;
    ifid_instr_n       = ifid_instr;
    ifid_pc_plus4_n    = ifid_pc_plus4;
    ifid_valid_n       = ifid_valid;
    hold_buf_n         = hold_buf;
    redirect_pending_n = redirect_pending;
    redirect_pc_n      = redirect_pc;

    if (if_flush) begin
      ifid_valid_n = 1'b0;
      ifid_instr_n = NOP_INSTR;
      if (state == HOLD) begin
        pc_n    = pcnext;
        state_n = FETCH;
      end else if (ack_fire) begin
        // A newer redirect supersedes any older pending one.
        pc_n               = pcnext;
        redirect_pending_n = 1'b0;
      end else begin
        // The outstanding request keeps its address; redirect once it lands.
        redirect_pending_n = 1'b1;
        redirect_pc_n      = pcnext;
      end
    end else if (state == FETCH) begin
      if (redirect_pending) begin
        if (ack_fire) begin
          pc_n               = redirect_pc;
          redirect_pending_n = 1'b0;
        end
        if (!stall_if) begin
          ifid_valid_n = 1'b0;
          ifid_instr_n = NOP_INSTR;
        end
      end else if (ack_fire) begin
        if (!stall_if) begin
          ifid_instr_n    = imem_rdata;
          ifid_pc_plus4_n = pc_plus4;
          ifid_valid_n    = 1'b1;
          pc_n            = pcnext;
        end else begin
          hold_buf_n = imem_rdata;
          state_n    = HOLD;
        end
      end else if (!stall_if) begin
        ifid_valid_n = 1'b0;
        ifid_instr_n = NOP_INSTR;
      end
    end else if (!stall_if) begin
      ifid_instr_n    = hold_buf;
      ifid_pc_plus4_n = pc_plus4;
      ifid_valid_n    = 1'b1;
      pc_n            = pcnext;
      state_n         = FETCH;
    end
  end

endmodule
